rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: depth of the reset-deassertion synchronizer; legal values are 2 or greater.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles to wait after synchronized release before rst_core_n is released; legal values are 1 or greater.
REQ-003 Parameter STAGE_GAP, default 4: cycles between the release of rst_core_n and the release of rst_periph_n; legal values are 1 or greater.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port sw_rst_req, input, 1 bit: synchronous software reset request, sampled only in RUN.
REQ-007 Port rst_core_n, output, 1 bit: core-domain reset, active-low.
REQ-008 Port rst_periph_n, output, 1 bit: peripheral-domain reset, active-low.
REQ-009 Port rst_done, output, 1 bit: high once the sequence is complete.
REQ-010 Port rst_cnt, output, 8 bits: count of accepted software resets; present only with RST_CNT_EN.

Function
REQ-011 The block SHALL implement the states RESET, SYNC, HOLD, GAP, DONE and RUN.
REQ-012 Edge numbering: rising edge 1 is the first clk rising edge after rst_n rises.
REQ-013 RESET -> SYNC at edge 1; the synchronized release SHALL be high after edge SYNC_STAGES, entering HOLD.
REQ-014 HOLD: counter counts HOLD_CYCLES edges; rst_core_n SHALL rise after edge SYNC_STAGES+HOLD_CYCLES (edge 18 with defaults); state -> GAP.
REQ-015 GAP: rst_periph_n SHALL rise STAGE_GAP edges after rst_core_n (edge 22 with defaults); state -> DONE.
REQ-016 DONE: rst_done SHALL rise on the next edge (edge 23 with defaults); state -> RUN.
REQ-017 RUN with sw_rst_req=1 at an edge: on that edge rst_core_n, rst_periph_n and rst_done SHALL go low together, the counter SHALL clear and the state SHALL go to HOLD; the sequence then repeats from HOLD (core released HOLD_CYCLES edges later, periph released STAGE_GAP edges after that).
REQ-018 sw_rst_req outside RUN SHALL be ignored; a request held high across re-entry to RUN SHALL trigger a further sequence.
REQ-019 Output ordering invariant: rst_periph_n high implies rst_core_n high; rst_done high implies both are high.
REQ-020 The counter SHALL be $clog2(max(HOLD_CYCLES,STAGE_GAP)+1) bits wide and SHALL never wrap.

Reset
REQ-021 rst_n low SHALL immediately (asynchronously) drive rst_core_n=0, rst_periph_n=0, rst_done=0, rst_cnt=0, the synchronizer to all zeros, the counter to 0 and the state to RESET.
REQ-022 rst_n assertion in any state, including mid-HOLD or mid-GAP, SHALL abort the sequence; after release, timing SHALL restart from edge 1.
REQ-023 Outputs SHALL be register-driven and glitch-free; no combinational path SHALL exist from rst_n deassertion to any output.

Configuration
REQ-024 With RST_CNT_EN defined: rst_cnt SHALL increment on each accepted sw_rst_req and saturate at 255; it SHALL be cleared only by rst_n.
REQ-025 Without RST_CNT_EN: the rst_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package rst_seq_pkg SHALL hold the state enum typedef, the default parameter constants and the rst_cnt width constant (8).
REQ-027 Sub-module rst_sync SHALL implement the SYNC_STAGES-deep async-assert/sync-deassert flop chain; rst_sequencer SHALL instantiate it once.

Verification
REQ-028 Power-on, defaults: rst_n low for 355 ns then high -> rst_core_n rises after edge 18, rst_periph_n after edge 22, rst_done after edge 23.
REQ-029 Mid-sequence abort: rst_n pulsed low at edge 10 -> all outputs low within the same cycle; after release, rst_core_n rises 18 edges later.
REQ-030 Software reset: one-cycle sw_rst_req in RUN -> all outputs low next edge; rst_core_n back high 16 edges later, rst_periph_n 4 edges after that, rst_done 1 edge after that; rst_cnt=1.
REQ-031 sw_rst_req=1 throughout HOLD after power-on -> ignored until RUN; a second sequence starts at the first RUN edge.
REQ-032 RST_CNT_EN: 260 software resets -> rst_cnt saturates at 255; a subsequent rst_n pulse -> 0.
REQ-033 Parameter sweep SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1 -> rst_core_n after edge 4, rst_periph_n after edge 5, rst_done after edge 6; the REQ-019 invariant is checked every cycle.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the reset sequencer.
//   state_t          - sequencer FSM states
//   DEF_*            - default parameter values
//   RST_CNT_W        - width of the software-reset counter output
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_SYNC  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_RUN   = 3'd5
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGE_GAP   = 4;
    localparam int RST_CNT_W       = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert / sync-deassert reset synchronizer chain.
//   clk      - clock
//   rst_n    - asynchronous active-low reset input
//   o_sync_n - synchronized release (last stage)
//   o_pre_n  - stage feeding the last one; lets a consumer act on the
//              same edge at which o_sync_n goes high
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_sync_n,
    output logic o_pre_n
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[STAGES-2:0], 1'b1};
    end

    assign o_sync_n = r_chain[STAGES-1];
    assign o_pre_n  = r_chain[STAGES-2];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release (core, then peripherals, then done)
// with synchronous software reset.
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   sw_rst_req   - software reset request, honoured only in RUN
//   rst_core_n   - core-domain reset, active-low
//   rst_periph_n - peripheral-domain reset, active-low
//   rst_done     - sequence complete
//   rst_cnt      - saturating count of accepted software resets
//                  (present only when RST_CNT_EN is defined)
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req,
    output logic                 rst_core_n,
    output logic                 rst_periph_n,
    output logic                 rst_done
`ifdef RST_CNT_EN
    ,
    output logic [RST_CNT_W-1:0] rst_cnt
`endif
);

    localparam int CW = $clog2(max2(HOLD_CYCLES, STAGE_GAP) + 1);

    state_t        r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          r_core_n, r_periph_n, r_done;
    logic          w_next_core_n, w_next_periph_n, w_next_done;
    logic          w_sync_n, w_pre_n, w_sw_acc, w_hold_end, w_gap_end;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_sync_n (w_sync_n),
        .o_pre_n  (w_pre_n)
    );

    assign w_sw_acc   = (r_state == ST_RUN) && sw_rst_req;
    assign w_hold_end = (r_cnt == CW'(HOLD_CYCLES - 1)) && w_sync_n;
    assign w_gap_end  = (r_cnt == CW'(STAGE_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_core_n   <= 1'b0;
            r_periph_n <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_core_n   <= w_next_core_n;
            r_periph_n <= w_next_periph_n;
            r_done     <= w_next_done;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_core_n   = r_core_n;
        w_next_periph_n = r_periph_n;
        w_next_done     = r_done;
        case (r_state)
            ST_RESET: w_next_state = ST_SYNC;
            // Enter HOLD on the edge at which the synchronized release appears.
            ST_SYNC: begin
                if (w_pre_n) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = '0;
                end
            end
            ST_HOLD: begin
                if (w_hold_end) begin
                    w_next_state  = ST_GAP;
                    w_next_cnt    = '0;
                    w_next_core_n = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_next_state    = ST_DONE;
                    w_next_cnt      = '0;
                    w_next_periph_n = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_RUN;
                w_next_done  = 1'b1;
            end
            ST_RUN: begin
                if (w_sw_acc) begin
                    w_next_state    = ST_HOLD;
                    w_next_cnt      = '0;
                    w_next_core_n   = 1'b0;
                    w_next_periph_n = 1'b0;
                    w_next_done     = 1'b0;
                end
            end
            default: w_next_state = ST_RESET;
        endcase
    end

    assign rst_core_n   = r_core_n;
    assign rst_periph_n = r_periph_n;
    assign rst_done     = r_done;

`ifdef RST_CNT_EN
    logic [RST_CNT_W-1:0] r_rst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_rst_cnt <= '0;
        else if (w_sw_acc && r_rst_cnt != '1) r_rst_cnt <= r_rst_cnt + 1'b1;
    end

    assign rst_cnt = r_rst_cnt;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed self-checking bench for rst_sequencer
// (default parameters plus a SYNC_STAGES=3/HOLD_CYCLES=1/STAGE_GAP=1 instance).
module tb_rst_sequencer;

    logic clk = 1'b1;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic sw2 = 1'b0;
    logic core, periph, done, core2, periph2, done2;
`ifdef RST_CNT_EN
    logic [7:0] cnt, cnt2;
`endif
    int n_chk = 0;
    int n_err = 0;
    int e = 0;

    always #5 clk = ~clk;

    rst_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw),
        .rst_core_n   (core),
        .rst_periph_n (periph),
        .rst_done     (done)
`ifdef RST_CNT_EN
        ,
        .rst_cnt      (cnt)
`endif
    );

    rst_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw2),
        .rst_core_n   (core2),
        .rst_periph_n (periph2),
        .rst_done     (done2)
`ifdef RST_CNT_EN
        ,
        .rst_cnt      (cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int t);
        while (e < t) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    // Ordering invariant on both instances, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_dut", 8'((!periph || core) && (!done || (core && periph))), 8'd1);
            chk("inv_dut2", 8'((!periph2 || core2) && (!done2 || (core2 && periph2))), 8'd1);
        end
    end

    initial begin
        #100;
        chk("rst_core", 8'(core), 8'd0);
        chk("rst_periph", 8'(periph), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_core2", 8'(core2), 8'd0);
        chk("rst_done2", 8'(done2), 8'd0);
`ifdef RST_CNT_EN
        chk("rst_cnt", cnt, 8'd0);
`endif
        #255;
        rst_n = 1'b1;
        e = 0;
        step_to(3);  chk("p2_core_e3", 8'(core2), 8'd0);
        step_to(4);  chk("p2_core_e4", 8'(core2), 8'd1);
                     chk("p2_periph_e4", 8'(periph2), 8'd0);
        step_to(5);  chk("p2_periph_e5", 8'(periph2), 8'd1);
                     chk("p2_done_e5", 8'(done2), 8'd0);
        step_to(6);  chk("p2_done_e6", 8'(done2), 8'd1);
        step_to(17); chk("po_core_e17", 8'(core), 8'd0);
        step_to(18); chk("po_core_e18", 8'(core), 8'd1);
                     chk("po_periph_e18", 8'(periph), 8'd0);
        step_to(21); chk("po_periph_e21", 8'(periph), 8'd0);
        step_to(22); chk("po_periph_e22", 8'(periph), 8'd1);
                     chk("po_done_e22", 8'(done), 8'd0);
        step_to(23); chk("po_done_e23", 8'(done), 8'd1);

        step_to(25);
        sw = 1'b1;
        step_to(26);
        sw = 1'b0;
        chk("sw_core_low", 8'(core), 8'd0);
        chk("sw_periph_low", 8'(periph), 8'd0);
        chk("sw_done_low", 8'(done), 8'd0);
        chk("sw_done2_kept", 8'(done2), 8'd1);
`ifdef RST_CNT_EN
        chk("sw_cnt1", cnt, 8'd1);
`endif
        step_to(41); chk("sw_core_e41", 8'(core), 8'd0);
        step_to(42); chk("sw_core_e42", 8'(core), 8'd1);
                     chk("sw_periph_e42", 8'(periph), 8'd0);
        step_to(45); chk("sw_periph_e45", 8'(periph), 8'd0);
        step_to(46); chk("sw_periph_e46", 8'(periph), 8'd1);
                     chk("sw_done_e46", 8'(done), 8'd0);
        step_to(47); chk("sw_done_e47", 8'(done), 8'd1);

        rst_n = 1'b0;
        #1;
        chk("async_core", 8'(core), 8'd0);
        chk("async_periph", 8'(periph), 8'd0);
        chk("async_done", 8'(done), 8'd0);
        chk("async_done2", 8'(done2), 8'd0);
`ifdef RST_CNT_EN
        chk("async_cnt", cnt, 8'd0);
`endif
        #2;
        rst_n = 1'b1;
        e = 0;
        step_to(10);
        chk("ab10_done2_pre", 8'(done2), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("ab10_done2", 8'(done2), 8'd0);
        chk("ab10_core", 8'(core), 8'd0);
        #2;
        rst_n = 1'b1;
        e = 0;
        step_to(17); chk("ab10_core_e17", 8'(core), 8'd0);
        step_to(18); chk("ab10_core_e18", 8'(core), 8'd1);
        step_to(20);
        rst_n = 1'b0;
        #1;
        chk("ab20_core", 8'(core), 8'd0);
        chk("ab20_periph", 8'(periph), 8'd0);
        #2;
        rst_n = 1'b1;
        e = 0;
        sw = 1'b1;
        step_to(17); chk("hold_core_e17", 8'(core), 8'd0);
        step_to(18); chk("hold_core_e18", 8'(core), 8'd1);
        step_to(22); chk("hold_periph_e22", 8'(periph), 8'd1);
        step_to(23); chk("hold_done_e23", 8'(done), 8'd1);
        step_to(24);
        sw = 1'b0;
        chk("rerun_core_e24", 8'(core), 8'd0);
        chk("rerun_periph_e24", 8'(periph), 8'd0);
        chk("rerun_done_e24", 8'(done), 8'd0);
`ifdef RST_CNT_EN
        chk("rerun_cnt", cnt, 8'd1);
`endif
        step_to(39); chk("rerun_core_e39", 8'(core), 8'd0);
        step_to(40); chk("rerun_core_e40", 8'(core), 8'd1);
        step_to(44); chk("rerun_periph_e44", 8'(periph), 8'd1);
        step_to(45); chk("rerun_done_e45", 8'(done), 8'd1);

`ifdef RST_CNT_EN
        for (int i = 0; i < 259; i++) begin
            int k;
            sw = 1'b1;
            step_to(e + 1);
            sw = 1'b0;
            k = 0;
            while (!done && k < 100) begin
                step_to(e + 1);
                k++;
            end
            if (!done) begin
                chk("sat_done_wait", 8'(done), 8'd1);
                break;
            end
        end
        chk("sat_cnt", cnt, 8'd255);
        rst_n = 1'b0;
        #1;
        chk("sat_cnt_clr", cnt, 8'd0);
        #2;
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
